uart_txbuffer: RTL and testbench

- Transmit-side counterpart of the UART receive buffer. Host logic pushes bytes into an 8-entry FIFO, and the block serialises them on `tx` as 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Bit timing comes from a free-running baud counter using the same convention as the receive side.
- Sits between a byte producer (command/response logic) and the board UART TX pin.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_gen.sv | 31 +++
 rtl/uart_txbuffer.sv | 154 +++++++++++++++
 tb/tb_uart_txbuffer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud default, state encodings, FIFO sizing.
package uart_pkg;

    // Baud counter terminal value; a bit period is BAUD_PER_DEFAULT+1 clocks.
    localparam int BAUD_PER_DEFAULT = 10416;
    localparam int BAUD_W           = 14;

    // Transmit FIFO sizing: 8 bytes, 3-bit pointers, 4-bit occupancy (0..8).
    localparam int FIFO_DEPTH = 8;
    localparam int PTR_W      = 3;
    localparam int CNT_W      = 4;

    // State encodings shared with the receive side (3 bits wide).
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3
    } uart_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running baud counter with a registered one-clock tick after each wrap.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int BAUD_PER = BAUD_PER_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [BAUD_W-1:0] baud_ctr_reg;
    logic              tick_reg;

    // Count 0..BAUD_PER and wrap; tick is high in the cycle following the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_ctr_reg <= '0;
            tick_reg     <= 1'b0;
        end else if (baud_ctr_reg == BAUD_W'(BAUD_PER)) begin
            baud_ctr_reg <= '0;
            tick_reg     <= 1'b1;
        end else begin
            baud_ctr_reg <= baud_ctr_reg + 1'b1;
            tick_reg     <= 1'b0;
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/uart_txbuffer.sv
// 8-byte transmit FIFO feeding an 8N1 serialiser (start, 8 data LSB first, stop).
module uart_txbuffer
    import uart_pkg::*;
#(
    parameter int BAUD_PER = BAUD_PER_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic [7:0]       wdata,
    output logic             tx,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             data_sent
);

    logic tick;
    logic adv;
    logic push;
    logic pop;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [CNT_W-1:0] count_reg;

    uart_state_t state_reg, state_next;
    logic        tx_reg, tx_next;
    logic [7:0]  txsr_reg, txsr_next;
    logic [2:0]  bit_ctr_reg, bit_ctr_next;
    logic        data_sent_reg, data_sent_next;

    uart_baud_gen #(.BAUD_PER(BAUD_PER)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign adv   = tick & en;
    assign full  = (count_reg == CNT_W'(FIFO_DEPTH));
    assign empty = (count_reg == '0);
    // A write while full is dropped even if a pop frees a slot this same cycle.
    assign push  = wr & ~full;

    // FIFO storage; contents are intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_reg] <= wdata;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (pop) begin
                head_reg <= head_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Serialiser state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            tx_reg        <= 1'b1;
            txsr_reg      <= '0;
            bit_ctr_reg   <= '0;
            data_sent_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tx_reg        <= tx_next;
            txsr_reg      <= txsr_next;
            bit_ctr_reg   <= bit_ctr_next;
            data_sent_reg <= data_sent_next;
        end
    end

    // Next-state logic; everything holds unless this is a qualified baud tick.
    // The byte is copied into txsr at the pop so later writes to the slot are harmless.
    always_comb begin
        state_next     = state_reg;
        tx_next        = tx_reg;
        txsr_next      = txsr_reg;
        bit_ctr_next   = bit_ctr_reg;
        data_sent_next = 1'b0;
        pop            = 1'b0;
        if (adv) begin
            case (state_reg)
                S_IDLE: begin
                    if (!empty) begin
                        txsr_next  = mem[head_reg];
                        pop        = 1'b1;
                        tx_next    = 1'b0;
                        state_next = S_START;
                    end else begin
                        tx_next = 1'b1;
                    end
                end
                S_START: begin
                    tx_next      = txsr_reg[0];
                    bit_ctr_next = 3'd0;
                    state_next   = S_DATA;
                end
                S_DATA: begin
                    if (bit_ctr_reg == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = S_STOP;
                    end else begin
                        bit_ctr_next = bit_ctr_reg + 3'd1;
                        tx_next      = txsr_reg[bit_ctr_reg + 3'd1];
                    end
                end
                S_STOP: begin
                    data_sent_next = 1'b1;
                    // Chain straight into the next start bit when more data waits.
                    if (!empty) begin
                        txsr_next  = mem[head_reg];
                        pop        = 1'b1;
                        tx_next    = 1'b0;
                        state_next = S_START;
                    end else begin
                        tx_next    = 1'b1;
                        state_next = S_IDLE;
                    end
                end
                default: begin
                    tx_next    = 1'b1;
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    assign tx        = tx_reg;
    assign count     = count_reg;
    assign busy      = (state_reg != S_IDLE);
    assign data_sent = data_sent_reg;

endmodule

// File: tb/tb_uart_txbuffer.sv
// Bench for uart_txbuffer: scoreboard of accepted bytes, line-decoding monitor.
module tb_uart_txbuffer;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       en    = 1'b1;
    logic       wr    = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       tx, full, empty, busy, data_sent;
    logic [3:0] count;

    always #5 clk = ~clk;

    uart_txbuffer #(.BAUD_PER(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .wr        (wr),
        .wdata     (wdata),
        .tx        (tx),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .busy      (busy),
        .data_sent (data_sent)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: bytes accepted but not yet fully sent, and bytes not yet started.
    logic [7:0] exp_q[$];
    int         pending = 0;

    // Monitor state: frame decoding against a 4-clock bit grid anchored at the start edge.
    bit         in_frame     = 1'b0;
    int         bitn         = 0;
    int         cnt          = 0;
    logic       cur          = 1'b1;
    logic [7:0] shreg        = 8'h00;
    int         idle_wait    = 0;
    logic       last_rst     = 1'b1;
    logic       last_en      = 1'b1;
    int         last_pending = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic start_frame();
        in_frame  = 1'b1;
        bitn      = 0;
        cnt       = 0;
        cur       = 1'b0;
        idle_wait = 0;
        if (pending > 0) pending--;
        else fail_now("spurious_start");
    endtask

    // Monitor: sample away from the active edge and decode the serial line.
    always @(negedge clk) begin
        if (last_rst) begin
            chk("rst_tx", tx, 1);
            chk("rst_count", count, 0);
            chk("rst_empty", empty, 1);
            chk("rst_full", full, 0);
            chk("rst_busy", busy, 0);
            chk("rst_data_sent", data_sent, 0);
            in_frame  = 1'b0;
            pending   = 0;
            idle_wait = 0;
            exp_q.delete();
        end else begin
            if (in_frame) begin
                cnt++;
                if (cnt == 4) begin
                    cnt = 0;
                    if (last_en) begin
                        bitn++;
                        if (bitn <= 8) begin
                            shreg = {tx, shreg[7:1]};
                            cur   = tx;
                            chk("data_sent_mid", data_sent, 0);
                        end else if (bitn == 9) begin
                            chk("stop_bit", tx, 1);
                            cur = 1'b1;
                            chk("data_sent_mid", data_sent, 0);
                        end else begin
                            chk("data_sent_pulse", data_sent, 1);
                            if (exp_q.size() == 0) begin
                                fail_now("unexpected_frame");
                            end else begin
                                logic [7:0] e;
                                e = exp_q.pop_front();
                                $display("frame byte %02h expected %02h at %0t", shreg, e, $time);
                                chk("frame_byte", shreg, e);
                            end
                            in_frame = 1'b0;
                            chk("next_start", tx, (last_pending > 0) ? 0 : 1);
                            if (tx === 1'b0) start_frame();
                        end
                    end else begin
                        chk("stalled_bit", tx, cur);
                        chk("data_sent_stall", data_sent, 0);
                    end
                end else begin
                    chk("bit_stable", tx, cur);
                    chk("data_sent_quiet", data_sent, 0);
                end
            end else begin
                chk("data_sent_idle", data_sent, 0);
                if (tx === 1'b0) begin
                    start_frame();
                end else begin
                    chk("idle_tx", tx, 1);
                    if (last_pending > 0 && last_en) begin
                        idle_wait++;
                        if (idle_wait >= 4) begin
                            fail_now("start_latency");
                            idle_wait = 0;
                        end
                    end else begin
                        idle_wait = 0;
                    end
                end
            end
            chk("count", count, pending);
            chk("full", full, (pending == 8) ? 1 : 0);
            chk("empty", empty, (pending == 0) ? 1 : 0);
            chk("busy", busy, in_frame ? 1 : 0);
        end
        last_rst     = rst;
        last_en      = en;
        last_pending = pending;
    end

    // All stimulus tasks are entered and left at posedge+1.
    task automatic write_byte(input logic [7:0] b);
        wr    = 1'b1;
        wdata = b;
        @(posedge clk);
        if (pending < 8) begin
            pending++;
            exp_q.push_back(b);
        end
        #1 wr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || in_frame || pending != 0) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (t >= 20000) fail_now("drain_timeout");
        idle(3);
    endtask

    task automatic wait_bit(input int n);
        int t = 0;
        while (!(in_frame && bitn == n) && t < 2000) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (t >= 2000) fail_now("wait_bit_timeout");
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(20);

        // Single frame.
        write_byte(8'hA5);
        drain();

        // Three bytes back to back.
        write_byte(8'h01);
        write_byte(8'h02);
        write_byte(8'h03);
        drain();

        // Fill while stalled; the ninth byte is dropped.
        en = 1'b0;
        for (int i = 0; i < 9; i++) write_byte(8'(8'h10 + i));
        idle(2);
        chk("full_when_stalled", full, 1);
        chk("count_when_stalled", count, 8);
        en = 1'b1;
        drain();

        // Stall in the middle of data bit 3 of 0xFF.
        write_byte(8'hFF);
        wait_bit(4);
        idle(1);
        en = 1'b0;
        idle(10);
        en = 1'b1;
        drain();

        // Reset during data bit 5 with two bytes still queued.
        write_byte(8'(($urandom & 8'h7F) | 8'h01));
        write_byte(8'($urandom));
        write_byte(8'($urandom));
        wait_bit(6);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(5);
        write_byte(8'h3C);
        drain();

        // Randomised writes with random en gating.
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = int'($urandom_range(0, 30));
            for (int g = 0; g < gap; g++) begin
                en = ($urandom_range(0, 7) != 0);
                idle(1);
            end
            write_byte(8'($urandom));
        end
        en = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        fail_now("global_timeout");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
